// File: rtl/phy_reg_free_list_pkg.sv
// Shared core definitions for the physical register free list.
// The physical register number width remains a shared define; the
// architectural register count and free-list depth derivation live here.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 7
`endif

package phy_reg_free_list_pkg;

  localparam int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH;
  localparam int CORE_PHY_REG_NUM       = 2 ** PHYSICAL_REG_NUM_WIDTH;
  localparam int CORE_ARCH_REG_NUM      = 32;

  // Registers not bound to an architectural register at reset are free.
  function automatic int free_list_depth(input int phy_reg_num, input int arch_reg_num);
    return phy_reg_num - arch_reg_num;
  endfunction

  // Pointer width able to address DEPTH entries (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/phy_reg_free_list_circ_ptr_inc.sv
// Modulo-DEPTH pointer increment; DEPTH need not be a power of two.
module phy_reg_free_list_circ_ptr_inc #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [PTR_W-1:0] ptr_nxt
);

  // Advance by one when enabled, wrapping from DEPTH-1 back to 0.
  always_comb begin
    ptr_nxt = ptr;
    if (en) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/phy_reg_free_list.sv
// Physical register free list: a circular FIFO of free register numbers.
// Decode pulls destination registers from the head; commit returns
// registers at the tail.
//
// Handshake: the allocation port is valid/ready style. alloc_ready is high
// whenever the registered count is non-zero and alloc_phy_reg is then the
// head entry in the same cycle. A grant happens only on a cycle where
// alloc_req and alloc_ready are both high; otherwise the requester holds
// alloc_req and retries. A same-cycle free never bypasses to an empty list.
// free_valid is a one-cycle push with no back-pressure: a push of register 0
// is ignored, and a push into a full list without a same-cycle grant is
// dropped and latches err_overflow.
module phy_reg_free_list
  import phy_reg_free_list_pkg::*;
#(
  parameter int PHY_REG_NUM  = 2 ** `PHYSICAL_REG_NUM_WIDTH,
  parameter int ARCH_REG_NUM = CORE_ARCH_REG_NUM
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               alloc_req,
  output logic                                               alloc_ready,
  output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]                 alloc_phy_reg,
  input  logic                                               free_valid,
  input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]                 free_phy_reg,
  output logic [$clog2(PHY_REG_NUM-ARCH_REG_NUM+1)-1:0]      free_count,
  output logic                                               err_overflow
);

  localparam int DEPTH  = free_list_depth(PHY_REG_NUM, ARCH_REG_NUM);
  localparam int PREG_W = `PHYSICAL_REG_NUM_WIDTH;
  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [PREG_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  head_nxt;
  logic [PTR_W-1:0]  tail_nxt;
  logic [CNT_W-1:0]  count;

  logic alloc_fire;
  logic free_nonzero;
  logic list_full;
  logic free_accept;
  logic overflow_hit;

  assign alloc_ready   = (count != '0);
  assign alloc_phy_reg = entries[head];
  assign free_count    = count;

  assign alloc_fire   = alloc_req & alloc_ready;
  // x0 stays permanently bound, so returning it is a no-op.
  assign free_nonzero = free_valid & (free_phy_reg != '0);
  assign list_full    = (count == CNT_W'(DEPTH));
  // When full, a same-cycle grant frees the slot the push lands in.
  assign free_accept  = free_nonzero & (~list_full | alloc_fire);
  assign overflow_hit = free_nonzero & list_full & ~alloc_fire;

  phy_reg_free_list_circ_ptr_inc #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_head_inc (
    .ptr     (head),
    .en      (alloc_fire),
    .ptr_nxt (head_nxt)
  );

  phy_reg_free_list_circ_ptr_inc #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_tail_inc (
    .ptr     (tail),
    .en      (free_accept),
    .ptr_nxt (tail_nxt)
  );

  // Storage: reset loads the unbound registers in order, otherwise push at tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= PREG_W'(ARCH_REG_NUM + i);
      end
    end else if (free_accept) begin
      entries[tail] <= free_phy_reg;
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= CNT_W'(DEPTH);
      err_overflow <= 1'b0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      case ({alloc_fire, free_accept})
        2'b10:   count <= count - CNT_W'(1);
        2'b01:   count <= count + CNT_W'(1);
        default: count <= count;
      endcase
      if (overflow_hit) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phy_reg_free_list.sv
// Bench for phy_reg_free_list with a queue-based reference model.
module tb_phy_reg_free_list;

  localparam int PREG_W = 7;
  localparam int ARCH   = 32;
  localparam int DEPTH  = 96;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_req;
  logic              alloc_ready;
  logic [PREG_W-1:0] alloc_phy_reg;
  logic              free_valid;
  logic [PREG_W-1:0] free_phy_reg;
  logic [CNT_W-1:0]  free_count;
  logic              err_overflow;

  always #5 clk = ~clk;

  phy_reg_free_list dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_req     (alloc_req),
    .alloc_ready   (alloc_ready),
    .alloc_phy_reg (alloc_phy_reg),
    .free_valid    (free_valid),
    .free_phy_reg  (free_phy_reg),
    .free_count    (free_count),
    .err_overflow  (err_overflow)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [PREG_W-1:0] exp_q[$];
  bit                m_err;
  int                n_cmp;
  int                n_bad;
  int                seq_k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(PREG_W'(ARCH + i));
    m_err = 1'b0;
  endtask

  task automatic check_outputs();
    check("ready", 32'(alloc_ready), 32'(exp_q.size() != 0));
    check("count", 32'(free_count), 32'(exp_q.size()));
    check("err", 32'(err_overflow), 32'(m_err));
    if (exp_q.size() != 0) check("grant", 32'(alloc_phy_reg), 32'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  // Called shortly after a falling edge; returns shortly after the next one.
  task automatic step(input bit areq, input bit fv, input int freg);
    int sz;
    bit fire;
    bit nz;
    alloc_req    = areq;
    free_valid   = fv;
    free_phy_reg = PREG_W'(freg);
    #1;
    check_outputs();
    sz   = exp_q.size();
    fire = areq && (sz != 0);
    nz   = fv && (freg != 0);
    @(posedge clk);
    if (fire) void'(exp_q.pop_front());
    if (nz) begin
      if (sz == DEPTH && !fire) m_err = 1'b1;
      else exp_q.push_back(PREG_W'(freg));
    end
    @(negedge clk);
  endtask

  // Reset with requests asserted, which reset must override.
  task automatic do_reset();
    reset        = 1'b1;
    alloc_req    = 1'b1;
    free_valid   = 1'b1;
    free_phy_reg = PREG_W'(40);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset      = 1'b0;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    #1;
    check("rst_grant", 32'(alloc_phy_reg), 32'(ARCH));
    check("rst_count", 32'(free_count), 32'(DEPTH));
    check("rst_ready", 32'(alloc_ready), 32'd1);
    check("rst_err", 32'(err_overflow), 32'd0);
  endtask

  function automatic int next_seq_reg();
    int v;
    v = (100 + seq_k) % 128;
    seq_k++;
    if (v == 0) begin
      v = (100 + seq_k) % 128;
      seq_k++;
    end
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_bad = 0; seq_k = 0;
    reset = 1'b1; alloc_req = 1'b0; free_valid = 1'b0; free_phy_reg = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Drain the whole list: grants come out as 32..127 in order.
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("drain_grant", 32'(alloc_phy_reg), 32'(ARCH + i));
      step(1'b1, 1'b0, 0);
    end
    #1;
    check("empty_ready", 32'(alloc_ready), 32'd0);
    check("empty_count", 32'(free_count), 32'd0);

    // Free into an empty list while requesting: no grant this cycle.
    step(1'b1, 1'b1, 5);
    #1;
    check("nobypass_ready", 32'(alloc_ready), 32'd1);
    check("nobypass_grant", 32'(alloc_phy_reg), 32'd5);

    // Bring the count to 10, then return x0.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 50 + i);
    step(1'b0, 1'b1, 0);
    #1;
    check("x0_count", 32'(free_count), 32'd10);
    check("x0_err", 32'(err_overflow), 32'd0);

    // Overflow while full, then a free accepted alongside a grant.
    do_reset();
    step(1'b0, 1'b1, 40);
    #1;
    check("ovf_set", 32'(err_overflow), 32'd1);
    check("ovf_count", 32'(free_count), 32'(DEPTH));
    step(1'b1, 1'b1, 40);
    #1;
    check("full_swap_count", 32'(free_count), 32'(DEPTH));
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, 0);
    #1;
    check("wrapped_grant", 32'(alloc_phy_reg), 32'd40);
    check("ovf_sticky", 32'(err_overflow), 32'd1);
    step(1'b1, 1'b0, 0);

    // Drain, then mixed traffic returning 100.. mod 128 (skipping 0).
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0);
    for (int i = 0; i < 200; i++) begin
      bit areq;
      bit fv;
      areq = ($urandom_range(0, 9) < 5);
      fv   = ($urandom_range(0, 9) < 6);
      step(areq, fv, fv ? next_seq_reg() : 0);
    end

    // Reset mid-stream with 17 entries free.
    do_reset();
    for (int i = 0; i < DEPTH - 17; i++) step(1'b1, 1'b0, 0);
    #1;
    check("mid_count", 32'(free_count), 32'd17);
    step(1'b0, 1'b1, 0);
    do_reset();

    // Free-heavy random traffic with arbitrary register numbers.
    for (int i = 0; i < 300; i++) begin
      bit areq;
      bit fv;
      areq = ($urandom_range(0, 9) < 3);
      fv   = ($urandom_range(0, 9) < 7);
      step(areq, fv, $urandom_range(0, 127));
    end
    for (int i = 0; i < 150; i++) begin
      bit areq;
      bit fv;
      areq = ($urandom_range(0, 9) < 8);
      fv   = ($urandom_range(0, 9) < 3);
      step(areq, fv, $urandom_range(0, 127));
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
